// File: rtl/unidade_controle_niveis.sv
// Control FSM for the drone game with lives, levels, pause and post-hit invulnerability.
// Sits between input conditioning (edge detectors, move timer, collision/map logic) and the
// datapath. A collision or timeout costs one life. Finishing a map advances the level until the
// last one is cleared.
//
// Ports:
//   clock, reset                 clock (rising edge) and synchronous active-high reset
//   iniciar, confirma, pausa     start, menu-confirm and pause-toggle pulses
//   timeout, fim_mapa, colisao   move timer expired, map finished, collision (valid in CHECA)
//   borda_movimento              movement command edge
//   vidas_sel                    lives chosen in the lives menu
//   zeraPosicoes .. perdeu       registered Moore control/status outputs
//   invulneravel                 invulnerability counter is nonzero
//   vidas_restantes, nivel       lives left and current 0-based level
//   db_estado                    current state code (4'hF if illegal)
module unidade_controle_niveis #(
  parameter int unsigned N_VIDAS_MAX  = 3,
  parameter int unsigned W_VIDAS      = 2,
  parameter int unsigned N_NIVEIS     = 4,
  parameter int unsigned W_NIVEL      = 2,
  parameter int unsigned INVUL_CICLOS = 16,
  parameter int unsigned W_INVUL      = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               confirma,
  input  logic               pausa,
  input  logic               timeout,
  input  logic               fim_mapa,
  input  logic               colisao,
  input  logic               borda_movimento,
  input  logic [W_VIDAS-1:0] vidas_sel,
  output logic               zeraPosicoes,
  output logic               zeraT,
  output logic               contaT,
  output logic               escolhe_modo,
  output logic               escolhe_vida,
  output logic               desloca,
  output logic               atualiza_out,
  output logic               checa_colisao_out,
  output logic               perde_vida,
  output logic               carrega_nivel,
  output logic               pausado,
  output logic               venceu,
  output logic               perdeu,
  output logic               invulneravel,
  output logic [W_VIDAS-1:0] vidas_restantes,
  output logic [W_NIVEL-1:0] nivel,
  output logic [3:0]         db_estado
);

  typedef enum logic [3:0] {
    StInicial     = 4'h0,
    StPreparacao  = 4'h1,
    StModo        = 4'h2,
    StEspera      = 4'h3,
    StDeslocamento = 4'h4,
    StCheca       = 4'h5,
    StProximo     = 4'h6,
    StDerrota     = 4'h7,
    StVitoria     = 4'h8,
    StVidas       = 4'h9,
    StAtualiza    = 4'hA,
    StPerdeVida   = 4'hB,
    StProxNivel   = 4'hC,
    StPausa       = 4'hD
  } estado_t;

  localparam logic [W_VIDAS-1:0] VidasMax    = W_VIDAS'(N_VIDAS_MAX);
  localparam logic [W_NIVEL-1:0] UltimoNivel = W_NIVEL'(N_NIVEIS - 1);
  localparam logic [W_INVUL-1:0] InvulCarga  = W_INVUL'(INVUL_CICLOS);

  estado_t            estado_q, estado_d;
  logic [W_INVUL-1:0] invul_q;
  logic [16:0]        saidas_q;

  assign invulneravel = (invul_q != '0);

  // Output bundle {13 control/status bits, 4-bit state code} for a given state.
  function automatic logic [16:0] decodifica(input estado_t e);
    logic [12:0] s;
    logic [3:0]  db;
    s  = '0;
    db = e;
    case (e)
      StInicial:      s[12:11] = 2'b11;  // zeraPosicoes, zeraT
      StPreparacao:   s[12:11] = 2'b11;
      StModo:         s[9]     = 1'b1;
      StVidas:        s[8]     = 1'b1;
      StEspera:       s[10]    = 1'b1;
      StDeslocamento: s[7]     = 1'b1;
      StAtualiza:     s[6]     = 1'b1;
      StCheca:        s[5]     = 1'b1;
      StProximo:      s[11]    = 1'b1;
      StPerdeVida:    begin s[11] = 1'b1; s[4] = 1'b1; end
      StProxNivel:    s[3]     = 1'b1;
      StPausa:        s[2]     = 1'b1;
      StVitoria:      s[1]     = 1'b1;
      StDerrota:      s[0]     = 1'b1;
      default:        db       = 4'hF;
    endcase
    return {s, db};
  endfunction

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      StInicial:      if (iniciar) estado_d = StModo;
      StModo:         if (confirma) estado_d = StVidas;
      StVidas:        if (confirma) estado_d = StPreparacao;
      StPreparacao:   estado_d = StEspera;
      StEspera: begin
        if (timeout)              estado_d = StPerdeVida;
        else if (pausa)           estado_d = StPausa;
        else if (borda_movimento) estado_d = StDeslocamento;
      end
      StPausa:        if (pausa) estado_d = StEspera;
      StDeslocamento: estado_d = StAtualiza;
      StAtualiza:     estado_d = StCheca;
      StCheca:        estado_d = (colisao && !invulneravel) ? StPerdeVida : StProximo;
      StPerdeVida:    estado_d = (vidas_restantes <= W_VIDAS'(1)) ? StDerrota : StEspera;
      StProximo: begin
        if (fim_mapa) estado_d = (nivel == UltimoNivel) ? StVitoria : StProxNivel;
        else          estado_d = StEspera;
      end
      StProxNivel:    estado_d = StPreparacao;
      StDerrota:      if (iniciar) estado_d = StModo;
      StVitoria:      if (iniciar) estado_d = StModo;
      default:        estado_d = StInicial;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q        <= StInicial;
      vidas_restantes <= '0;
      nivel           <= '0;
      invul_q         <= '0;
      saidas_q        <= decodifica(StInicial);
    end else begin
      estado_q <= estado_d;
      // Outputs are registered from the next state so they line up with estado_q.
      saidas_q <= decodifica(estado_d);

      if (estado_q == StVidas && confirma) begin
        if (vidas_sel == '0)          vidas_restantes <= W_VIDAS'(1);
        else if (vidas_sel > VidasMax) vidas_restantes <= VidasMax;
        else                          vidas_restantes <= vidas_sel;
        nivel <= '0;
      end else if (estado_q == StPerdeVida && vidas_restantes != '0) begin
        vidas_restantes <= vidas_restantes - W_VIDAS'(1);
      end else if (estado_q == StProxNivel) begin
        nivel <= nivel + W_NIVEL'(1);
      end

      if (estado_q == StPerdeVida && estado_d == StEspera) begin
        invul_q <= InvulCarga;
      end else if (invul_q != '0 && estado_q != StPausa) begin
        invul_q <= invul_q - W_INVUL'(1);
      end
    end
  end

  assign {zeraPosicoes, zeraT, contaT, escolhe_modo, escolhe_vida, desloca, atualiza_out,
          checa_colisao_out, perde_vida, carrega_nivel, pausado, venceu, perdeu} = saidas_q[16:4];
  assign db_estado = saidas_q[3:0];

endmodule

// File: tb/tb_unidade_controle_niveis.sv
module tb_unidade_controle_niveis;

  logic       clock = 1'b0;
  logic       reset, iniciar, confirma, pausa, timeout, fim_mapa, colisao, borda_movimento;
  logic [1:0] vidas_sel;
  logic       zeraPosicoes, zeraT, contaT, escolhe_modo, escolhe_vida, desloca, atualiza_out;
  logic       checa_colisao_out, perde_vida, carrega_nivel, pausado, venceu, perdeu, invulneravel;
  logic [1:0] vidas_restantes, nivel;
  logic [3:0] db_estado;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  unidade_controle_niveis dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .confirma(confirma), .pausa(pausa),
    .timeout(timeout), .fim_mapa(fim_mapa), .colisao(colisao),
    .borda_movimento(borda_movimento), .vidas_sel(vidas_sel),
    .zeraPosicoes(zeraPosicoes), .zeraT(zeraT), .contaT(contaT), .escolhe_modo(escolhe_modo),
    .escolhe_vida(escolhe_vida), .desloca(desloca), .atualiza_out(atualiza_out),
    .checa_colisao_out(checa_colisao_out), .perde_vida(perde_vida),
    .carrega_nivel(carrega_nivel), .pausado(pausado), .venceu(venceu), .perdeu(perdeu),
    .invulneravel(invulneravel), .vidas_restantes(vidas_restantes), .nivel(nivel),
    .db_estado(db_estado)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and sample 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    iniciar = 0; confirma = 0; pausa = 0; timeout = 0;
    fim_mapa = 0; colisao = 0; borda_movimento = 0;
  endtask

  // From ESPERA: move, check (no collision), finish the map.
  task automatic play_level(input logic [1:0] lvl, input bit last);
    borda_movimento = 1; step(); borda_movimento = 0;
    check("desloca_st", db_estado, 4'h4);
    step(); check("atualiza_st", db_estado, 4'hA);
    step(); check("checa_st", db_estado, 4'h5);
    step(); check("proximo_st", db_estado, 4'h6);
    fim_mapa = 1; step(); fim_mapa = 0;
    if (last) begin
      check("vitoria_st", db_estado, 4'h8);
      check("venceu", {3'b0, venceu}, 4'h1);
    end else begin
      check("prox_nivel_st", db_estado, 4'hC);
      check("carrega_nivel", {3'b0, carrega_nivel}, 4'h1);
      check("nivel_before", {2'b0, nivel}, {2'b0, lvl});
      step(); check("prep_st", db_estado, 4'h1);
      check("nivel_inc", {2'b0, nivel}, {2'b0, lvl + 2'd1});
      step(); check("espera_st", db_estado, 4'h3);
    end
  endtask

  initial begin
    clear_inputs();
    vidas_sel = 0;
    reset = 1;
    step(); step();
    check("rst_estado", db_estado, 4'h0);
    check("rst_zeraPos", {3'b0, zeraPosicoes}, 4'h1);
    check("rst_zeraT", {3'b0, zeraT}, 4'h1);
    check("rst_vidas", {2'b0, vidas_restantes}, 4'h0);
    check("rst_nivel", {2'b0, nivel}, 4'h0);
    check("rst_invul", {3'b0, invulneravel}, 4'h0);
    reset = 0;

    // 1 life via vidas_sel = 0, lost on timeout.
    iniciar = 1; step(); iniciar = 0;
    check("modo_st", db_estado, 4'h2);
    check("escolhe_modo", {3'b0, escolhe_modo}, 4'h1);
    confirma = 1; step();
    check("vidas_st", db_estado, 4'h9);
    check("escolhe_vida", {3'b0, escolhe_vida}, 4'h1);
    vidas_sel = 0; step(); confirma = 0;
    check("prep_st", db_estado, 4'h1);
    check("vidas_sel0", {2'b0, vidas_restantes}, 4'h1);
    step();
    check("espera_st", db_estado, 4'h3);
    check("contaT", {3'b0, contaT}, 4'h1);
    timeout = 1; step(); timeout = 0;
    check("perde_st", db_estado, 4'hB);
    check("perde_vida", {3'b0, perde_vida}, 4'h1);
    check("perde_zeraT", {3'b0, zeraT}, 4'h1);
    step();
    check("derrota_st", db_estado, 4'h7);
    check("perdeu", {3'b0, perdeu}, 4'h1);
    check("derrota_vidas", {2'b0, vidas_restantes}, 4'h0);
    check("derrota_invul", {3'b0, invulneravel}, 4'h0);

    // Restart with 3 lives, take a hit.
    iniciar = 1; step(); iniciar = 0;
    check("restart_modo", db_estado, 4'h2);
    confirma = 1; step(); vidas_sel = 3; step(); confirma = 0;
    check("vidas_sel3", {2'b0, vidas_restantes}, 4'h3);
    step(); check("espera_st", db_estado, 4'h3);
    borda_movimento = 1; step(); borda_movimento = 0;
    step(); step(); check("checa_st", db_estado, 4'h5);
    check("checa_out", {3'b0, checa_colisao_out}, 4'h1);
    colisao = 1; step(); colisao = 0;
    check("hit_perde_st", db_estado, 4'hB);
    check("hit_vidas_hold", {2'b0, vidas_restantes}, 4'h3);
    step();
    check("hit_espera_st", db_estado, 4'h3);
    check("hit_vidas", {2'b0, vidas_restantes}, 4'h2);
    check("hit_invul", {3'b0, invulneravel}, 4'h1);
    // Counter now 16. Collision while invulnerable is ignored.
    borda_movimento = 1; step(); borda_movimento = 0;  // 15
    step();                                            // 14
    colisao = 1; step();                               // 13, CHECA
    step(); colisao = 0;                               // 12
    check("invul_ignore", db_estado, 4'h6);
    check("invul_vidas", {2'b0, vidas_restantes}, 4'h2);
    step();                                            // 11, ESPERA
    check("back_espera", db_estado, 4'h3);
    pausa = 1; step(); pausa = 0;                      // 10, PAUSA
    check("pausa_st", db_estado, 4'hD);
    check("pausado", {3'b0, pausado}, 4'h1);
    check("pausa_contaT", {3'b0, contaT}, 4'h0);
    timeout = 1; step(); step(); step(); timeout = 0;  // frozen at 10
    check("pausa_timeout", db_estado, 4'hD);
    pausa = 1; step(); pausa = 0;                      // 10, ESPERA
    check("unpause", db_estado, 4'h3);
    for (int i = 0; i < 9; i++) step();                // 1
    check("invul_last", {3'b0, invulneravel}, 4'h1);
    step();                                            // 0
    check("invul_end", {3'b0, invulneravel}, 4'h0);

    // Advance to level 2, then reset mid-game.
    play_level(2'd0, 1'b0);
    play_level(2'd1, 1'b0);
    check("mid_nivel", {2'b0, nivel}, 4'h2);
    reset = 1; step(); reset = 0;
    check("midrst_estado", db_estado, 4'h0);
    check("midrst_nivel", {2'b0, nivel}, 4'h0);
    check("midrst_vidas", {2'b0, vidas_restantes}, 4'h0);
    check("midrst_zeraPos", {3'b0, zeraPosicoes}, 4'h1);

    // Full run through all four levels.
    iniciar = 1; step(); iniciar = 0;
    confirma = 1; step(); vidas_sel = 2; step(); confirma = 0;
    check("vidas_sel2", {2'b0, vidas_restantes}, 4'h2);
    step();
    play_level(2'd0, 1'b0);
    play_level(2'd1, 1'b0);
    play_level(2'd2, 1'b0);
    play_level(2'd3, 1'b1);
    check("win_vidas", {2'b0, vidas_restantes}, 4'h2);
    step(); check("win_hold", db_estado, 4'h8);
    iniciar = 1; step(); iniciar = 0;
    check("win_restart", db_estado, 4'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
